cache_fill_fsm: RTL and testbench

- Miss handler on the other end of the data cache's fill interface.
- When the cache reports a miss, it fetches the missing 16-byte block from main memory as eight 16-bit words.
- It streams each returned word into the cache data array, then writes the tag/metadata entry in one final cycle.
- It sits between the data cache and the multi-cycle main memory. The pipeline stays stalled while busy is high.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/fill_word_counter.sv | 37 +++
 rtl/cache_fill_fsm.sv | 120 ++++++++++++
 tb/tb_cache_fill_fsm.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache-side definitions: fill FSM state encoding and block geometry.
// Also used by the instruction-cache fill path and the memory arbiter.
package cache_pkg;

    localparam int unsigned ADDR_W          = 16;
    localparam int unsigned WORDS_PER_BLOCK = 8;
    localparam int unsigned BLOCK_OFF_W     = 4;
    localparam int unsigned WORD_CNT_W      = 3;
    localparam int unsigned BLK_W           = ADDR_W - BLOCK_OFF_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } fill_state_e;

    // Byte address of a 16-bit word inside a block; the offset never carries into the block bits.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [BLK_W-1:0]      blk,
                                                    input logic [WORD_CNT_W-1:0] idx);
        return {blk, idx, 1'b0};
    endfunction

endpackage

// File: rtl/fill_word_counter.sv
// Word-index counter for block fills: synchronous clear, increment enable,
// terminal count on the last word of a block.
module fill_word_counter
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  inc_i,
    output logic [WORD_CNT_W-1:0] cnt_o,
    output logic                  tc_o
);

    logic [WORD_CNT_W-1:0] cnt_q;
    logic [WORD_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + WORD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == WORD_CNT_W'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/cache_fill_fsm.sv
// Data-cache miss handler: fetches a 16-byte block as eight words from main memory,
// streams them into the data array, then writes the tag entry in one final cycle.
module cache_fill_fsm
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected_i,
    input  logic [ADDR_W-1:0] miss_addr_i,
    input  logic              mem_data_valid_i,
    input  logic [ADDR_W-1:0] mem_data_i,
    output logic              busy_o,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              write_data_array_o,
    output logic              write_tag_array_o,
    output logic [ADDR_W-1:0] cache_addr_o,
    output logic [ADDR_W-1:0] cache_data_o
);

    fill_state_e           state_q, state_d;
    logic [BLK_W-1:0]      blk_q, blk_d;
    logic [ADDR_W-1:0]     miss_q, miss_d;
    logic                  req_done_q, req_done_d;

    logic                  cnt_clr;
    logic                  req_inc;
    logic                  ack_inc;
    logic [WORD_CNT_W-1:0] req_cnt;
    logic [WORD_CNT_W-1:0] ack_cnt;
    logic                  req_tc;
    logic                  ack_tc;

    fill_word_counter u_req_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .inc_i (req_inc),
        .cnt_o (req_cnt),
        .tc_o  (req_tc)
    );

    fill_word_counter u_ack_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .inc_i (ack_inc),
        .cnt_o (ack_cnt),
        .tc_o  (ack_tc)
    );

    // Next state and outputs; requests run ahead of responses without waiting on them.
    always_comb begin
        state_d            = state_q;
        blk_d              = blk_q;
        miss_d             = miss_q;
        req_done_d         = req_done_q;
        cnt_clr            = 1'b0;
        req_inc            = 1'b0;
        ack_inc            = 1'b0;
        busy_o             = 1'b0;
        mem_en_o           = 1'b0;
        mem_addr_o         = '0;
        write_data_array_o = 1'b0;
        write_tag_array_o  = 1'b0;
        cache_addr_o       = miss_addr_i;
        cache_data_o       = mem_data_i;

        case (state_q)
            IDLE: begin
                if (miss_detected_i) begin
                    state_d    = FILL;
                    blk_d      = miss_addr_i[ADDR_W-1:BLOCK_OFF_W];
                    miss_d     = miss_addr_i;
                    req_done_d = 1'b0;
                    cnt_clr    = 1'b1;
                end
            end
            FILL: begin
                busy_o             = 1'b1;
                mem_en_o           = ~req_done_q;
                mem_addr_o         = word_addr(blk_q, req_cnt);
                req_inc            = ~req_done_q;
                if (!req_done_q && req_tc) begin
                    req_done_d = 1'b1;
                end
                write_data_array_o = mem_data_valid_i;
                cache_addr_o       = word_addr(blk_q, ack_cnt);
                ack_inc            = mem_data_valid_i;
                if (mem_data_valid_i && ack_tc) begin
                    state_d = TAG;
                end
            end
            TAG: begin
                busy_o            = 1'b1;
                write_tag_array_o = 1'b1;
                cache_addr_o      = miss_q;
                state_d           = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            blk_q      <= '0;
            miss_q     <= '0;
            req_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_q      <= blk_d;
            miss_q     <= miss_d;
            req_done_q <= req_done_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: per-cycle timeline checks for several memory
// latencies, a zero-latency vector table, held/changing miss, and mid-fill reset.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data;
    logic        busy;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] cache_addr;
    logic [15:0] cache_data;

    int n_pass  = 0;
    int n_total = 0;

    cache_fill_fsm dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .miss_detected_i    (miss_detected),
        .miss_addr_i        (miss_addr),
        .mem_data_valid_i   (mem_data_valid),
        .mem_data_i         (mem_data),
        .busy_o             (busy),
        .mem_en_o           (mem_en),
        .mem_addr_o         (mem_addr),
        .write_data_array_o (write_data_array),
        .write_tag_array_o  (write_tag_array),
        .cache_addr_o       (cache_addr),
        .cache_data_o       (cache_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    typedef struct {
        logic        miss;
        logic        valid;
        logic [15:0] data;
        logic        e_busy;
        logic        e_en;
        logic [15:0] e_maddr;
        logic        e_wda;
        logic        e_wta;
        logic [15:0] e_caddr;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic drive(input logic m, input logic [15:0] a, input logic v, input logic [15:0] d);
        @(posedge clk);
        #1;
        miss_detected  = m;
        miss_addr      = a;
        mem_data_valid = v;
        mem_data       = d;
        #1;
    endtask

    // One complete fill from IDLE. vmask bit c = mem_data_valid in cycle c after the miss edge.
    task automatic run_fill(input logic [15:0] addr, input logic [31:0] vmask, input logic hold,
                            input logic [15:0] addr2, input int pen);
        logic [15:0] base;
        logic [15:0] a;
        int          k;
        int          tag_c;
        bit          in_tag;
        base   = {addr[15:4], 4'h0};
        k      = 0;
        tag_c  = -1;
        in_tag = 1'b0;
        drive(1'b1, addr, 1'b0, 16'h0);
        chk("idle busy", 16'(busy), 16'h0);
        chk("idle mem_en", 16'(mem_en), 16'h0);
        chk("idle mem_addr", mem_addr, 16'h0);
        chk("idle cache_addr", cache_addr, addr);
        for (int c = 1; c < 32 && tag_c < 0; c++) begin
            a = (hold && c >= 2) ? addr2 : addr;
            drive(hold, a, vmask[c], 16'hD000 + 16'(k));
            chk($sformatf("busy c%0d", c), 16'(busy), 16'h1);
            if (!in_tag) begin
                chk($sformatf("mem_en c%0d", c), 16'(mem_en), 16'(c <= 8));
                if (c <= 8) chk($sformatf("mem_addr c%0d", c), mem_addr, base + 16'(2 * (c - 1)));
                chk($sformatf("wda c%0d", c), 16'(write_data_array), 16'(vmask[c]));
                chk($sformatf("wta c%0d", c), 16'(write_tag_array), 16'h0);
                if (vmask[c]) begin
                    chk($sformatf("cache_addr c%0d", c), cache_addr, base + 16'(2 * k));
                    chk($sformatf("cache_data c%0d", c), cache_data, 16'hD000 + 16'(k));
                    k++;
                    if (k == 8) in_tag = 1'b1;
                end
            end else begin
                chk($sformatf("tag wta c%0d", c), 16'(write_tag_array), 16'h1);
                chk($sformatf("tag wda c%0d", c), 16'(write_data_array), 16'h0);
                chk($sformatf("tag mem_en c%0d", c), 16'(mem_en), 16'h0);
                chk($sformatf("tag cache_addr c%0d", c), cache_addr, addr);
                tag_c = c;
            end
        end
        if (tag_c < 0) begin
            n_total++;
            $display("FAIL fill %h: no TAG cycle within 31 cycles, got %0d writes expected 8", addr, k);
        end else begin
            chk("miss penalty", 16'(tag_c + 1), 16'(pen));
        end
    endtask

    initial begin
        // Zero-latency fill of 16'h5432: valid rides with each request; spurious valids in IDLE.
        tbl[0] = '{1'b1, 1'b1, 16'hEEEE, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h5432};
        for (int c = 1; c <= 8; c++)
            tbl[c] = '{1'b0, 1'b1, 16'h0100 + 16'(c), 1'b1, 1'b1, 16'h5430 + 16'(2 * (c - 1)),
                       1'b1, 1'b0, 16'h5430 + 16'(2 * (c - 1))};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h5432};
        tbl[10] = '{1'b0, 1'b1, 16'hBAD0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h5432};
        tbl[11] = '{1'b0, 1'b1, 16'hBAD1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h5432};

        rst_n          = 1'b0;
        miss_detected  = 1'b0;
        miss_addr      = 16'h0;
        mem_data_valid = 1'b0;
        mem_data       = 16'h0;
        #2;
        chk("reset busy", 16'(busy), 16'h0);
        chk("reset mem_en", 16'(mem_en), 16'h0);
        chk("reset wda", 16'(write_data_array), 16'h0);
        chk("reset wta", 16'(write_tag_array), 16'h0);
        chk("reset mem_addr", mem_addr, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency 4: penalty 1+4+8+1.
        run_fill(16'h1234, 32'h0000_1FE0, 1'b0, 16'h0, 14);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].miss, 16'h5432, tbl[i].valid, tbl[i].data);
            chk($sformatf("tbl%0d busy", i), 16'(busy), 16'(tbl[i].e_busy));
            chk($sformatf("tbl%0d mem_en", i), 16'(mem_en), 16'(tbl[i].e_en));
            if (tbl[i].e_en || !tbl[i].e_busy)
                chk($sformatf("tbl%0d mem_addr", i), mem_addr, tbl[i].e_maddr);
            chk($sformatf("tbl%0d wda", i), 16'(write_data_array), 16'(tbl[i].e_wda));
            chk($sformatf("tbl%0d wta", i), 16'(write_tag_array), 16'(tbl[i].e_wta));
            chk($sformatf("tbl%0d cache_addr", i), cache_addr, tbl[i].e_caddr);
            if (tbl[i].e_wda) chk($sformatf("tbl%0d cache_data", i), cache_data, tbl[i].data);
        end

        // Irregular valids, miss held high and miss_addr moved to the next miss mid-fill.
        run_fill(16'h7F1C, 32'h0000_7398, 1'b1, 16'h1A34, 16);
        // Held miss is taken only once back in IDLE: new fill at base 1A30, latency 2.
        run_fill(16'h1A34, 32'h0000_07F8, 1'b0, 16'h0, 12);

        // Reset after three words of a latency-1 fill.
        drive(1'b1, 16'h2468, 1'b0, 16'h0);
        drive(1'b0, 16'h2468, 1'b0, 16'h0);
        for (int c = 0; c < 3; c++) drive(1'b0, 16'h2468, 1'b1, 16'h0300 + 16'(c));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 16'(busy), 16'h0);
        chk("midrst mem_en", 16'(mem_en), 16'h0);
        chk("midrst wda", 16'(write_data_array), 16'h0);
        chk("midrst wta", 16'(write_tag_array), 16'h0);
        chk("midrst mem_addr", mem_addr, 16'h0);
        drive(1'b0, 16'h2468, 1'b1, 16'h0310);
        chk("inrst wda", 16'(write_data_array), 16'h0);
        rst_n = 1'b1;
        drive(1'b0, 16'h2468, 1'b1, 16'h0311);
        chk("late valid wda", 16'(write_data_array), 16'h0);
        chk("late valid busy", 16'(busy), 16'h0);
        run_fill(16'h2468, 32'h0000_03FC, 1'b0, 16'h0, 11);

        drive(1'b0, 16'h2468, 1'b0, 16'h0);
        chk("final busy", 16'(busy), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
